// File: rtl/mapache64.sv
// mapache64: shared VGA raster timing constants and types
// Provides the 640x480@60 timing constants, the 2x-scaled game window
// geometry, the raster coordinate type and the registered output bundle.
package mapache64;
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int X_OFFSET  = 64;
  localparam int GAME_W    = 256;
  typedef logic [9:0] raster_coord_t;
  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic       in_window;
    logic       hblank;
    logic       vblank;
    logic       vblank_start;
    logic [7:0] current_x;
    logic [7:0] current_y;
    logic [7:0] frame_count;
  } timing_out_t;
endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-N up counter with enable and wrap pulse
// Ports: clk_i/rst_ni (async active-low), inc_en_i advances the count,
// count_o is the current value, wrap_o is high on the cycle it rolls to 0.
module mod_counter #(
  parameter int WIDTH   = 10,
  parameter int MODULUS = 800
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);
  logic [WIDTH-1:0] count_q, count_d;
  assign wrap_o  = inc_en_i && (count_q == WIDTH'(MODULUS - 1));
  assign count_o = count_q;
  always_comb count_d = wrap_o ? '0 : count_q + WIDTH'(inc_en_i);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/video_timing.sv
// video_timing: VGA raster timing plus 256x240 game-space coordinates
// Ports: gpu_clk/rst_n (async active-low); hsync/vsync (active low),
// visible, in_window, hblank, vblank, vblank_start pulse, current_x/y game
// coordinates and frame_count. All outputs are registered from the same
// (h,v) so they lag the counters by one cycle and stay mutually aligned.
module video_timing
  import mapache64::*;
#(
  parameter int H_VISIBLE = mapache64::H_VISIBLE,
  parameter int H_FRONT   = mapache64::H_FRONT,
  parameter int H_SYNC    = mapache64::H_SYNC,
  parameter int H_BACK    = mapache64::H_BACK,
  parameter int V_VISIBLE = mapache64::V_VISIBLE,
  parameter int V_FRONT   = mapache64::V_FRONT,
  parameter int V_SYNC    = mapache64::V_SYNC,
  parameter int V_BACK    = mapache64::V_BACK,
  parameter int X_OFFSET  = mapache64::X_OFFSET,
  parameter int H_WINDOW  = 2 * mapache64::GAME_W
) (
  input  logic       gpu_clk,
  input  logic       rst_n,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       in_window,
  output logic [7:0] current_x,
  output logic [7:0] current_y,
  output logic       hblank,
  output logic       vblank,
  output logic       vblank_start,
  output logic [7:0] frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam raster_coord_t HV  = raster_coord_t'(H_VISIBLE);
  localparam raster_coord_t HS0 = raster_coord_t'(H_VISIBLE + H_FRONT);
  localparam raster_coord_t HS1 = raster_coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam raster_coord_t VV  = raster_coord_t'(V_VISIBLE);
  localparam raster_coord_t VS0 = raster_coord_t'(V_VISIBLE + V_FRONT);
  localparam raster_coord_t VS1 = raster_coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam raster_coord_t XO  = raster_coord_t'(X_OFFSET);
  localparam raster_coord_t XE  = raster_coord_t'(X_OFFSET + H_WINDOW);
  localparam timing_out_t OUT_RST = '{hsync: 1'b1, vsync: 1'b1, default: '0};
  raster_coord_t h, v;
  logic          h_wrap, v_wrap;
  timing_out_t   out_q, out_d;
  mod_counter #(.WIDTH($bits(raster_coord_t)), .MODULUS(H_TOTAL)) u_h (
    .clk_i   (gpu_clk),
    .rst_ni  (rst_n),
    .inc_en_i(1'b1),
    .count_o (h),
    .wrap_o  (h_wrap)
  );
  mod_counter #(.WIDTH($bits(raster_coord_t)), .MODULUS(V_TOTAL)) u_v (
    .clk_i   (gpu_clk),
    .rst_ni  (rst_n),
    .inc_en_i(h_wrap),
    .count_o (v),
    .wrap_o  (v_wrap)
  );
  // The line counter only advances on a pixel wrap, so a frame wrap must coincide with one.
  assert property (@(posedge gpu_clk) disable iff (!rst_n) v_wrap |-> h_wrap);
  always_comb begin
    out_d              = OUT_RST;
    out_d.visible      = (h < HV) && (v < VV);
    out_d.in_window    = out_d.visible && (h >= XO) && (h < XE);
    // Game pixels are doubled horizontally: drop bit 0 of the window-relative column.
    out_d.current_x    = out_d.in_window ? 8'((h - XO) >> 1) : '0;
    out_d.current_y    = (v < VV) ? 8'(v >> 1) : '0;
    out_d.hsync        = !((h >= HS0) && (h < HS1));
    out_d.vsync        = !((v >= VS0) && (v < VS1));
    out_d.hblank       = h >= HV;
    out_d.vblank       = v >= VV;
    out_d.vblank_start = (h == '0) && (v == VV);
    out_d.frame_count  = out_q.frame_count + 8'(out_d.vblank_start);
  end
  always_ff @(posedge gpu_clk or negedge rst_n)
    if (!rst_n) out_q <= OUT_RST;
    else out_q <= out_d;
  assign hsync        = out_q.hsync;
  assign vsync        = out_q.vsync;
  assign visible      = out_q.visible;
  assign in_window    = out_q.in_window;
  assign current_x    = out_q.current_x;
  assign current_y    = out_q.current_y;
  assign hblank       = out_q.hblank;
  assign vblank       = out_q.vblank;
  assign vblank_start = out_q.vblank_start;
  assign frame_count  = out_q.frame_count;
endmodule
